// File: rtl/mmwave_pkg.sv
// rtl/mmwave_pkg.sv - shared constants, types and helpers for the mmwave frame path
package mmwave_pkg;

    localparam logic MODE_NORMAL    = 1'b0;
    localparam logic MODE_TRANSPOSE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } ct_state_e;

    // Number of bits needed to hold value: floor(log2(value)) + 1.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// rtl/stream_skid_fifo.sv - 2-entry valid/ready buffer exposing occupancy for upstream credit
module stream_skid_fifo #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_tvalid,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic [1:0]       occupancy
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    logic             pop;

    // The writer guarantees room via the occupancy credit, so there is no s_tready.
    assign pop       = m_tvalid & m_tready;
    assign m_tvalid  = (count_q != 2'd0);
    assign m_tdata   = ent0_q;
    assign occupancy = count_q;

    always_comb begin
        count_d = count_q + {1'b0, s_tvalid} - {1'b0, pop};
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        if (pop) begin
            ent0_d = ent1_q;
            if (s_tvalid) begin
                if (count_q == 2'd1) ent0_d = s_tdata;
                else                 ent1_d = s_tdata;
            end
        end else if (s_tvalid) begin
            if (count_q == 2'd0) ent0_d = s_tdata;
            else                 ent1_d = s_tdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else begin
            count_q <= count_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

endmodule

// File: rtl/corner_turn_reader.sv
// rtl/corner_turn_reader.sv - streams a radar frame from block RAM in chirp-major or transposed order
module corner_turn_reader
    import mmwave_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CHIRPS  = 16,
    parameter int NUM_SAMPLES = 16,
    parameter int ADDR_WIDTH  = clogb2(NUM_CHIRPS * NUM_SAMPLES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  transpose,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_enb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_frame_last
);

    localparam int FW = DATA_WIDTH + 2;
    localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(NUM_SAMPLES);
    localparam logic [ADDR_WIDTH-1:0] CHIRP_END  = ADDR_WIDTH'(NUM_CHIRPS - 1);
    localparam logic [ADDR_WIDTH-1:0] SAMPLE_END = ADDR_WIDTH'(NUM_SAMPLES - 1);

    ct_state_e             state_q, state_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] inner_q, inner_d;
    logic [ADDR_WIDTH-1:0] outer_q, outer_d;
    logic                  in_flight_q, in_flight_d;
    logic                  last_q, last_d;
    logic                  flast_q, flast_d;
    logic                  done_q, done_d;

    logic                  inner_end, outer_end, issue, pop;
    logic [2:0]            credit;
    logic [1:0]            fifo_occ;
    logic                  fifo_valid;
    logic [FW-1:0]         fifo_head;

    assign pop          = m_valid & m_ready;
    assign m_valid      = fifo_valid;
    assign m_data       = fifo_head[DATA_WIDTH-1:0];
    assign m_last       = fifo_valid & fifo_head[DATA_WIDTH+1];
    assign m_frame_last = fifo_valid & fifo_head[DATA_WIDTH];
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign ram_enb      = issue;
    assign ram_addrb    = addr_q;

    // Outstanding beats = buffered + in flight, less the one leaving this cycle.
    always_comb begin
        credit    = {1'b0, fifo_occ} + {2'b00, in_flight_q} - {2'b00, pop};
        issue     = (state_q == ST_RUN) && (credit < 3'd2);
        inner_end = (mode_q == MODE_TRANSPOSE) ? (inner_q == CHIRP_END)  : (inner_q == SAMPLE_END);
        outer_end = (mode_q == MODE_TRANSPOSE) ? (outer_q == SAMPLE_END) : (outer_q == CHIRP_END);
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        addr_d      = addr_q;
        inner_d     = inner_q;
        outer_d     = outer_q;
        last_d      = last_q;
        flast_d     = flast_q;
        done_d      = 1'b0;
        in_flight_d = issue;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = transpose;
                    addr_d  = '0;
                    inner_d = '0;
                    outer_d = '0;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    last_d  = inner_end;
                    flast_d = inner_end & outer_end;
                    if (inner_end && outer_end) begin
                        state_d = ST_DRAIN;
                    end else if (inner_end) begin
                        inner_d = '0;
                        outer_d = outer_q + ONE;
                        // A new column starts at its own index; a new chirp just continues.
                        addr_d  = (mode_q == MODE_TRANSPOSE) ? outer_q + ONE : addr_q + ONE;
                    end else begin
                        inner_d = inner_q + ONE;
                        addr_d  = (mode_q == MODE_TRANSPOSE) ? addr_q + STRIDE : addr_q + ONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && m_frame_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_NORMAL;
            addr_q      <= '0;
            inner_q     <= '0;
            outer_q     <= '0;
            in_flight_q <= 1'b0;
            last_q      <= 1'b0;
            flast_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            inner_q     <= inner_d;
            outer_q     <= outer_d;
            in_flight_q <= in_flight_d;
            last_q      <= last_d;
            flast_q     <= flast_d;
            done_q      <= done_d;
        end
    end

    stream_skid_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_tvalid  (in_flight_q),
        .s_tdata   ({last_q, flast_q, ram_doutb}),
        .m_tvalid  (fifo_valid),
        .m_tready  (m_ready),
        .m_tdata   (fifo_head),
        .occupancy (fifo_occ)
    );

endmodule

// File: tb/tb_corner_turn_reader.sv
// tb/tb_corner_turn_reader.sv - table-driven scoreboard bench for corner_turn_reader
module tb_corner_turn_reader;

    localparam int DW = 32;
    localparam int NC = 4;
    localparam int NS = 3;
    localparam int N  = NC * NS;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          transpose = 1'b0;
    logic          m_ready = 1'b0;
    logic          busy, done, ram_enb, m_valid, m_last, m_frame_last;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_doutb, m_data;
    logic [DW-1:0] ram [16];

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_enb) ram_doutb <= ram[ram_addrb];

    corner_turn_reader #(
        .DATA_WIDTH  (DW),
        .NUM_CHIRPS  (NC),
        .NUM_SAMPLES (NS),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .transpose    (transpose),
        .busy         (busy),
        .done         (done),
        .ram_enb      (ram_enb),
        .ram_addrb    (ram_addrb),
        .ram_doutb    (ram_doutb),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_frame_last (m_frame_last)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          flast;
    } beat_t;

    // rdy: 0 = always ready, 1 = random 50%, 2 = stalled in cycles 3..12
    typedef struct {
        bit tr;
        int rdy;
        bit restart;
        int exp_beats;
        int exp_done;
        int exp_first;
        int exp_last_cyc;
        int exp_done_cyc;
        int exp_enb_early;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[6];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 1) return 1'($urandom_range(0, 1));
        if (mode == 2) return !(cyc >= 3 && cyc <= 12);
        return 1'b1;
    endfunction

    task automatic load_expected(input bit tr);
        beat_t b;
        sb.delete();
        for (int i = 0; i < N; i++) begin
            if (tr) begin
                b.data = DW'((i % NC) * NS + i / NC);
                b.last = ((i % NC) == NC - 1);
            end else begin
                b.data = DW'(i);
                b.last = ((i % NS) == NS - 1);
            end
            b.flast = (i == N - 1);
            sb.push_back(b);
        end
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ram_enb"}, ram_enb, 0);
        check({tag, "_ram_addrb"}, ram_addrb, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_m_frame_last"}, m_frame_last, 0);
    endtask

    task automatic run_frame(input vec_t v, input int abort_beats);
        int            issues, acc, dones, first_valid, last_acc, done_cyc, enb_early;
        logic          prev_v, prev_r, prev_l, prev_fl;
        logic [DW-1:0] prev_d;
        beat_t         e;
        issues = 0; acc = 0; dones = 0; enb_early = 0;
        first_valid = -1; last_acc = -1; done_cyc = -1;
        prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_fl = 1'b0; prev_d = '0;
        load_expected(v.tr);
        @(posedge clk);
        #1;
        start     = 1'b1;
        transpose = v.tr;
        m_ready   = ready_for(v.rdy, 0);
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (cyc == 0) check("busy_at_start", busy, 0);
            if (cyc == 1) check("busy_running", busy, 1);
            if (ram_enb) begin
                issues++;
                if (cyc <= 12) enb_early++;
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (prev_v && !prev_r) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_d);
                check("hold_tags", {m_last, m_frame_last}, {prev_l, prev_fl});
            end
            if (m_valid && m_ready) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("beat_data", m_data, e.data);
                    check("beat_last", m_last, e.last);
                    check("beat_frame_last", m_frame_last, e.flast);
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_beat: got data %0d expected no beat", m_data);
                end
                acc++;
                last_acc = cyc;
            end
            check("outstanding_le_2", (issues - acc) > 2, 0);
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) check("busy_after_done", busy, 0);
            prev_v = m_valid; prev_r = m_ready; prev_d = m_data;
            prev_l = m_last; prev_fl = m_frame_last;
            if (abort_beats > 0 && acc == abort_beats) return;
            if (done_cyc >= 0 && cyc == done_cyc + 2) break;
            @(posedge clk);
            #1;
            start     = v.restart && (cyc + 1 == 5);
            transpose = ~v.tr;
            m_ready   = ready_for(v.rdy, cyc + 1);
        end
        check("beat_count", acc, v.exp_beats);
        check("done_count", dones, v.exp_done);
        check("sb_empty", sb.size(), 0);
        if (v.exp_first >= 0)     check("first_valid_cycle", first_valid, v.exp_first);
        if (v.exp_last_cyc >= 0)  check("last_beat_cycle", last_acc, v.exp_last_cyc);
        if (v.exp_done_cyc >= 0)  check("done_cycle", done_cyc, v.exp_done_cyc);
        if (v.exp_enb_early >= 0) check("enb_during_stall", enb_early, v.exp_enb_early);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = DW'(i);
        vecs[0] = '{tr: 1'b0, rdy: 0, restart: 1'b0, exp_beats: N, exp_done: 1, exp_first: 3, exp_last_cyc: N + 2, exp_done_cyc: N + 3, exp_enb_early: -1};
        vecs[1] = '{tr: 1'b1, rdy: 0, restart: 1'b0, exp_beats: N, exp_done: 1, exp_first: 3, exp_last_cyc: N + 2, exp_done_cyc: N + 3, exp_enb_early: -1};
        vecs[2] = '{tr: 1'b0, rdy: 1, restart: 1'b0, exp_beats: N, exp_done: 1, exp_first: 3, exp_last_cyc: -1, exp_done_cyc: -1, exp_enb_early: -1};
        vecs[3] = '{tr: 1'b1, rdy: 1, restart: 1'b0, exp_beats: N, exp_done: 1, exp_first: 3, exp_last_cyc: -1, exp_done_cyc: -1, exp_enb_early: -1};
        vecs[4] = '{tr: 1'b0, rdy: 0, restart: 1'b1, exp_beats: N, exp_done: 1, exp_first: 3, exp_last_cyc: N + 2, exp_done_cyc: N + 3, exp_enb_early: -1};
        vecs[5] = '{tr: 1'b0, rdy: 2, restart: 1'b0, exp_beats: N, exp_done: 1, exp_first: 3, exp_last_cyc: 24, exp_done_cyc: 25, exp_enb_early: 2};

        #12;
        check_outputs_reset("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            run_frame(vecs[k], 0);
            repeat (2) @(posedge clk);
        end

        run_frame(vecs[0], 5);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_reset("midreset");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midreset_no_done", done, 0);
            check("midreset_no_valid", m_valid, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(vecs[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
